// File: rtl/cc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cc_branch_unit
//  Purpose  : Condition-code register plus conditional-branch evaluator with a
//             single delay slot, annul handling and DCTI detection.
//             Optional macro CC_FORWARD_EN forwards same-cycle flags into the
//             evaluation of a cc-setting branch.
//  Revision : 1.0  initial release
// ============================================================================
module cc_branch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] flags_in,
    input  logic       cc_we,
    input  logic       instr_valid,
    input  logic       is_bcc,
    input  logic [3:0] cond,
    input  logic       annul_a,
    output logic [3:0] icc,
    output logic       taken,
    output logic       annul,
    output logic       in_slot,
    output logic       dcti_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] icc_q, icc_d;
    logic       annul_q, annul_d;
    logic       taken_q, taken_d;
    logic       dcti_q, dcti_d;

    logic       slot_annulled;
    logic       accept;
    logic [3:0] eval_flags;
    logic       cond_true;

    // Low three bits pick the base predicate, bit 3 inverts it (never/always included).
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic z, n, cy, v, base;
        z  = f[3];
        n  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = cy | z;
            3'd5:    base = cy;
            3'd6:    base = n;
            default: base = v;
        endcase
        return c[3] ? ~base : base;
    endfunction

    always_comb begin
        slot_annulled = (state_q == ST_SLOT) && annul_q;
        accept        = instr_valid && is_bcc && (state_q == ST_IDLE);
`ifdef CC_FORWARD_EN
        // A branch is only accepted in IDLE, so it can never be annulled itself.
        eval_flags    = (accept && cc_we) ? flags_in : icc_q;
`else
        eval_flags    = icc_q;
`endif
        cond_true     = cond_eval(cond, eval_flags);

        icc_d   = icc_q;
        state_d = state_q;
        annul_d = annul_q;
        taken_d = 1'b0;
        dcti_d  = 1'b0;

        if (instr_valid && cc_we && !slot_annulled) begin
            icc_d = flags_in;
        end

        if (accept) begin
            state_d = ST_SLOT;
            taken_d = cond_true;
            annul_d = annul_a && (!cond_true || (cond == 4'b1000));
        end else if ((state_q == ST_SLOT) && instr_valid) begin
            state_d = ST_IDLE;
            annul_d = 1'b0;
            dcti_d  = is_bcc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            icc_q   <= 4'b0000;
            annul_q <= 1'b0;
            taken_q <= 1'b0;
            dcti_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icc_q   <= icc_d;
            annul_q <= annul_d;
            taken_q <= taken_d;
            dcti_q  <= dcti_d;
        end
    end

    assign icc      = icc_q;
    assign taken    = taken_q;
    assign in_slot  = (state_q == ST_SLOT);
    assign annul    = (state_q == ST_SLOT) && annul_q;
    assign dcti_err = dcti_q;

endmodule
`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cc_branch_unit
//  Purpose  : Directed vector table, reset corner sequence and randomized
//             run against a behavioural model for cc_branch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cc_branch_unit;

`ifdef CC_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] flags_in;
    logic       cc_we, instr_valid, is_bcc, annul_a;
    logic [3:0] cond;
    logic [3:0] icc;
    logic       taken, annul, in_slot, dcti_err;

    int checks = 0;
    int passes = 0;

    cc_branch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .flags_in   (flags_in),
        .cc_we      (cc_we),
        .instr_valid(instr_valid),
        .is_bcc     (is_bcc),
        .cond       (cond),
        .annul_a    (annul_a),
        .icc        (icc),
        .taken      (taken),
        .annul      (annul),
        .in_slot    (in_slot),
        .dcti_err   (dcti_err)
    );

    always #5 clk = ~clk;

    // {icc[3:0], taken, annul, in_slot, dcti_err}
    typedef struct {
        logic       v, we, bcc, a;
        logic [3:0] cnd, flg;
        logic [7:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [7:0] outs();
        return {icc, taken, annul, in_slot, dcti_err};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got {icc,tk,an,sl,de}=%b required %b", name, act, exp);
    endtask

    task automatic drive(input logic v, we, bcc, a, input logic [3:0] cnd, flg);
        instr_valid = v; cc_we = we; is_bcc = bcc; annul_a = a; cond = cnd; flags_in = flg;
    endtask

    // Reference model: architectural state only, predicates straight from the condition table.
    logic [3:0] m_icc;
    bit         m_slot, m_annul, m_taken, m_dcti;

    function automatic bit pred(input logic [3:0] c, input logic [3:0] f);
        bit z = f[3], n = f[2], cy = f[1], v = f[0];
        case (c)
            4'h0: return 0;
            4'h1: return z;
            4'h2: return z | (n ^ v);
            4'h3: return n ^ v;
            4'h4: return cy | z;
            4'h5: return cy;
            4'h6: return n;
            4'h7: return v;
            4'h8: return 1;
            4'h9: return !z;
            4'hA: return !(z | (n ^ v));
            4'hB: return !(n ^ v);
            4'hC: return !(cy | z);
            4'hD: return !cy;
            4'hE: return !n;
            default: return !v;
        endcase
    endfunction

    task automatic model_step();
        bit annulled = m_slot && m_annul;
        bit is_branch = instr_valid && is_bcc && !m_slot;
        logic [3:0] e = (FWD && is_branch && cc_we) ? flags_in : m_icc;
        bit res = pred(cond, e);
        m_taken = is_branch && res;
        m_dcti  = m_slot && instr_valid && is_bcc;
        if (instr_valid && cc_we && !annulled) m_icc = flags_in;
        if (is_branch) begin
            m_slot  = 1;
            m_annul = annul_a && (!res || cond == 4'b1000);
        end else if (m_slot && instr_valid) begin
            m_slot  = 0;
            m_annul = 0;
        end
    endtask

    function automatic logic [7:0] model_outs();
        return {m_icc, m_taken, m_slot && m_annul, m_slot, m_dcti};
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 4'h0);
        #3;
        check("reset_state", outs(), 8'h00);
        #9 reset = 1'b0;

        //                v  we bcc a  cond     flags    {icc,tk,an,sl,de}
        vq.push_back(vec_t'{1, 1, 0, 0, 4'b0000, 4'b0100, {4'b0100, 4'b0000}});
        vq.push_back(vec_t'{1, 0, 1, 0, 4'b0011, 4'b0000, {4'b0100, 4'b1010}});
        vq.push_back(vec_t'{1, 0, 0, 0, 4'b0000, 4'b0000, {4'b0100, 4'b0000}});
        vq.push_back(vec_t'{1, 1, 0, 0, 4'b0000, 4'b1000, {4'b1000, 4'b0000}});
        vq.push_back(vec_t'{1, 0, 1, 1, 4'b1001, 4'b0000, {4'b1000, 4'b0110}});
        vq.push_back(vec_t'{1, 1, 0, 0, 4'b0000, 4'b0001, {4'b1000, 4'b0000}});
        vq.push_back(vec_t'{1, 0, 1, 1, 4'b1000, 4'b0000, {4'b1000, 4'b1110}});
        vq.push_back(vec_t'{0, 1, 1, 0, 4'b0000, 4'b0011, {4'b1000, 4'b0110}});
        vq.push_back(vec_t'{1, 0, 0, 0, 4'b0000, 4'b0000, {4'b1000, 4'b0000}});
        vq.push_back(vec_t'{1, 0, 1, 0, 4'b0000, 4'b0000, {4'b1000, 4'b0010}});
        vq.push_back(vec_t'{1, 0, 1, 0, 4'b1000, 4'b0000, {4'b1000, 4'b0001}});
        vq.push_back(vec_t'{0, 0, 0, 0, 4'b0000, 4'b0000, {4'b1000, 4'b0000}});
        vq.push_back(vec_t'{1, 1, 0, 0, 4'b0000, 4'b0000, {4'b0000, 4'b0000}});
        vq.push_back(vec_t'{1, 1, 1, 0, 4'b0001, 4'b1000, {4'b1000, FWD, 3'b010}});
        vq.push_back(vec_t'{1, 0, 0, 0, 4'b0000, 4'b0000, {4'b1000, 4'b0000}});
        vq.push_back(vec_t'{1, 0, 1, 1, 4'b1001, 4'b0000, {4'b1000, 4'b0110}});

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].we, vq[i].bcc, vq[i].a, vq[i].cnd, vq[i].flg);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs(), vq[i].exp);
        end

        // Asynchronous reset while in an annulled slot, with no clock edge in between.
        drive(0, 0, 0, 0, 4'h0, 4'h0);
        #2 reset = 1'b1;
        #1 check("async_reset_mid_slot", outs(), 8'h00);
        #2 reset = 1'b0;
        drive(1, 1, 0, 0, 4'h0, 4'b0110);
        @(posedge clk); #1;
        check("first_after_reset", outs(), {4'b0110, 4'b0000});
        drive(1, 0, 1, 0, 4'b0110, 4'h0);
        @(posedge clk); #1;
        check("branch_after_reset", outs(), {4'b0110, 4'b1010});

        // Randomized run from a clean reset.
        drive(0, 0, 0, 0, 4'h0, 4'h0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        m_icc = 4'h0; m_slot = 0; m_annul = 0; m_taken = 0; m_dcti = 0;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            model_step();
            @(posedge clk); #1;
            check($sformatf("rand%0d", i), outs(), model_outs());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
